// File: rtl/barrel_shift_pkg.sv
// Shared widths and FSM state type for the barrel-shift arbiter.
package barrel_shift_pkg;
   localparam int DATA_W = 16;
   localparam int AMT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;
endpackage

// File: rtl/CA2_Q4_16_bit_barrel_shifter.sv
// 16-bit rotate-left barrel shifter: one mux stage per amount bit,
// stage s rotates by 2**s when i_amt[s] is set.
module CA2_Q4_16_bit_barrel_shifter
   import barrel_shift_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   input  logic [AMT_W-1:0]  i_amt,
   output logic [DATA_W-1:0] o_data
);
   logic [AMT_W:0][DATA_W-1:0] w_stage;

   assign w_stage[0] = i_data;

   for (genvar s = 0; s < AMT_W; s++) begin : g_stage
      localparam int K = 1 << s;
      assign w_stage[s+1] = i_amt[s] ?
         {w_stage[s][DATA_W-1-K:0], w_stage[s][DATA_W-1 -: K]} : w_stage[s];
   end

   assign o_data = w_stage[AMT_W];
endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end for a shared barrel shifter. One
// transaction in flight: grant, hold operands stable for SETTLE_CYCLES,
// capture the rotated word, then hold it until the consumer accepts.
module barrel_shift_arbiter
   import barrel_shift_pkg::*;
#(
   parameter int SETTLE_CYCLES = 3
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [1:0][DATA_W-1:0]  req_data,
   input  logic [1:0][AMT_W-1:0]   req_amt,
   output logic [1:0]              req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_W-1:0]       res_data,
   output logic                    res_id,
   output logic                    busy
);
   // Counter only needs to hold SETTLE_CYCLES-1.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_op_data, r_res_data, w_shift;
   logic [AMT_W-1:0]  r_op_amt;
   logic              r_op_id, r_res_id, r_res_valid, r_last_grant;
   logic              w_grant_en, w_grant_id, w_capture, w_release;

   // Shifter sees only the operand registers, so requester inputs cannot
   // disturb a settling result.
   CA2_Q4_16_bit_barrel_shifter u_shifter (
      .i_data (r_op_data),
      .i_amt  (r_op_amt),
      .o_data (w_shift)
   );

   // Arbitration: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      w_grant_id = 1'b0;
      if (req_valid == 2'b11) w_grant_id = ~r_last_grant;
      else                    w_grant_id = req_valid[1];
   end

   // Next-state and strobe decode.
   always_comb begin
      w_next     = r_state;
      req_ready  = 2'b00;
      w_grant_en = 1'b0;
      w_capture  = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_grant_en            = 1'b1;
               req_ready[w_grant_id] = 1'b1;
               w_next                = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == '0) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_res_valid && res_ready) begin
               w_release = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register; reset overrides any pending transition.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Operand latch, settle counter, result capture and grant history.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_op_data    <= '0;
         r_op_amt     <= '0;
         r_op_id      <= 1'b0;
         r_res_data   <= '0;
         r_res_id     <= 1'b0;
         r_res_valid  <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         if (w_grant_en) begin
            r_op_data    <= req_data[w_grant_id];
            r_op_amt     <= req_amt[w_grant_id];
            r_op_id      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= CNT_LOAD;
         end else if (r_state == S_SETTLE && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_capture) begin
            r_res_data  <= w_shift;
            r_res_id    <= r_op_id;
            r_res_valid <= 1'b1;
         end else if (w_release) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_id    = r_res_id;
   assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed + randomized bench for barrel_shift_arbiter with a rotate/round-robin
// reference model.
module tb_barrel_shift_arbiter;
   localparam int SC = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0][15:0] req_data;
   logic [1:0][3:0]  req_amt;
   logic [1:0]       req_ready;
   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_data;
   logic             res_id;
   logic             busy;

   int checks = 0;
   int errors = 0;
   logic model_last;

   barrel_shift_arbiter #(.SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rotl(input logic [15:0] d, input logic [3:0] a);
      logic [31:0] t;
      t = {d, d} << a;
      return t[31:16];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction starting in IDLE just after a falling edge.
   task automatic txn(input logic [1:0] vld, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input int hold, input bit scram, input bit keep);
      logic        g;
      logic [15:0] exp_d;
      req_valid   = vld;
      req_data[0] = d0; req_data[1] = d1;
      req_amt[0]  = a0; req_amt[1]  = a1;
      res_ready   = 1'b0;
      g     = (vld == 2'b11) ? ~model_last : vld[1];
      exp_d = g ? rotl(d1, a1) : rotl(d0, a0);
      #1;
      chk("grant_onehot", {30'd0, req_ready}, 32'd1 << g);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      model_last = g;
      for (int k = 1; k <= SC + 1; k++) begin
         @(negedge clk);
         if (k == 1 && !keep) req_valid = 2'b00;
         if (scram) begin
            req_data[0] = 16'($urandom); req_data[1] = 16'($urandom);
            req_amt[0]  = 4'($urandom);  req_amt[1]  = 4'($urandom);
         end
         #1;
         chk("latency_valid", {31'd0, res_valid}, (k == SC + 1) ? 32'd1 : 32'd0);
         chk("settle_ready", {30'd0, req_ready}, 32'd0);
         chk("settle_busy", {31'd0, busy}, 32'd1);
      end
      chk("res_data", {16'd0, res_data}, {16'd0, exp_d});
      chk("res_id", {31'd0, res_id}, {31'd0, g});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         chk("hold_valid", {31'd0, res_valid}, 32'd1);
         chk("hold_data", {16'd0, res_data}, {16'd0, exp_d});
         chk("hold_id", {31'd0, res_id}, {31'd0, g});
         chk("hold_ready", {30'd0, req_ready}, 32'd0);
         chk("hold_busy", {31'd0, busy}, 32'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk("post_hs_valid", {31'd0, res_valid}, 32'd0);
      chk("post_hs_busy", {31'd0, busy}, 32'd0);
      chk("retain_data", {16'd0, res_data}, {16'd0, exp_d});
      chk("retain_id", {31'd0, res_id}, {31'd0, g});
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; req_data = '0; req_amt = '0; res_ready = 1'b0;
      model_last = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_data", {16'd0, res_data}, 32'd0);
      chk("rst_id", {31'd0, res_id}, 32'd0);
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("idle_noreq_ready", {30'd0, req_ready}, 32'd0);

      // Basic single requests, the second with operand scrambling while settling.
      txn(2'b01, 16'h0001, 16'h0000, 4'd0, 4'd0, 0, 1'b0, 1'b0);
      txn(2'b10, 16'h0000, 16'h0009, 4'd0, 4'd3, 1, 1'b1, 1'b0);

      // Both continuously valid: expect alternation 0,1,0,1.
      for (int i = 0; i < 4; i++)
         txn(2'b11, 16'h8001, 16'h00F0, 4'd1, 4'd15, i % 2, 1'b0, 1'b1);
      req_valid = 2'b00;

      // Long back-pressure in HOLD.
      txn(2'b01, 16'h1234, 16'h0000, 4'd4, 4'd0, 10, 1'b0, 1'b0);

      // Reset on the second settle cycle abandons the transaction.
      req_valid = 2'b01; req_data[0] = 16'hBEEF; req_amt[0] = 4'd5;
      #1;
      chk("abort_grant", {30'd0, req_ready}, 32'd1);
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      chk("abort_valid", {31'd0, res_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_data", {16'd0, res_data}, 32'd0);
      model_last = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("abort_no_result", {31'd0, res_valid}, 32'd0);
      end
      txn(2'b11, 16'h0F0F, 16'hF0F0, 4'd2, 4'd6, 0, 1'b0, 1'b0);

      // All rotate amounts on one pattern.
      for (int a = 0; a < 16; a++)
         txn(2'b01, 16'hA5C3, 16'h0000, 4'(a), 4'd0, 0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 24; i++)
         txn(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
             4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'b0);

      // Reset coinciding with a result handshake wins.
      req_valid = 2'b10; req_data[1] = 16'h00FF; req_amt[1] = 4'd8;
      #1;
      chk("rsths_grant", {30'd0, req_ready}, 32'd2);
      @(negedge clk); req_valid = 2'b00;
      repeat (SC) @(negedge clk);
      #1;
      chk("rsths_valid_pre", {31'd0, res_valid}, 32'd1);
      res_ready = 1'b1; rst = 1'b1;
      @(negedge clk); res_ready = 1'b0; rst = 1'b0; #1;
      chk("rsths_valid", {31'd0, res_valid}, 32'd0);
      chk("rsths_data", {16'd0, res_data}, 32'd0);
      chk("rsths_busy", {31'd0, busy}, 32'd0);
      model_last = 1'b1;
      txn(2'b11, 16'h0003, 16'h0005, 4'd1, 4'd1, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 SETTLE_CYCLES, default 3: cycles the operands are held stable on the shifter before the result is captured; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  [1:0]  request strobe per requester.
REQ-005 req_data  input  [1:0][15:0]  operand word per requester.
REQ-006 req_amt  input  [1:0][3:0]  rotate-left amount per requester.
REQ-007 req_ready  output  [1:0]  one-hot accept, high only in the grant cycle.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  result consumer accept.
REQ-010 res_data  output  16  rotated word.
REQ-011 res_id  output  1  index of the requester that owns res_data.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, SETTLE, HOLD.
REQ-014 IDLE: if any req_valid bit is set, grant one requester g, drive req_ready[g]=1 combinationally, latch req_data[g]/req_amt[g]/g into operand registers, load counter with SETTLE_CYCLES-1, go to SETTLE; otherwise stay in IDLE.
REQ-015 Arbitration: a single valid requester is granted; if both are valid, the requester not granted last wins; last_grant updates only on a grant.
REQ-016 req_ready SHALL be 2'b00 in SETTLE and HOLD, and in IDLE when no request is valid.
REQ-017 SETTLE: the shifter is driven only from the operand registers; changes on req_data/req_amt have no effect; the counter decrements each cycle.
REQ-018 SETTLE with counter==0: capture shifter output into res_data, operand id into res_id, set res_valid=1, go to HOLD.
REQ-019 Latency: res_valid asserts exactly SETTLE_CYCLES+1 cycles after the grant cycle.
REQ-020 Arithmetic: res_data = (d << amt) | (d >> (16-amt)), modulo 16 bits; amt=0 returns d unchanged.
REQ-021 HOLD: res_valid, res_data and res_id stay stable until res_valid&&res_ready; on that edge clear res_valid and go to IDLE.
REQ-022 Next grant occurs no earlier than the cycle after the result handshake (one transaction in flight).
REQ-023 res_data and res_id retain their last captured values while res_valid=0.
REQ-024 A requester deasserting req_valid before its grant is simply not served; there is no penalty and no stored state.

Reset
REQ-025 On rst: state=IDLE, res_valid=0, res_data=16'h0000, res_id=0, req_ready=0, busy=0, counter=0, last_grant=1 (requester 0 wins the first tie).
REQ-026 rst asserted mid-transaction abandons it; no result is produced; outputs take reset values the following cycle.
REQ-027 rst has priority over every FSM transition, including a simultaneous result handshake.

Structure
REQ-028 Package barrel_shift_pkg holds DATA_W=16, AMT_W=4, and the state enum type.
REQ-029 One sub-module: the team's existing 16-bit barrel shifter CA2_Q4_16_bit_barrel_shifter, instantiated once and driven from the operand registers.
REQ-030 The counter is only as wide as needed for SETTLE_CYCLES; no other storage is permitted beyond the operand, result and arbitration registers.

Verification
REQ-031 Reset, then req0: data=16'h0001, amt=0 -> res_data=16'h0001, res_id=0, res_valid exactly 4 cycles after the grant (SETTLE_CYCLES=3).
REQ-032 req1: data=16'h0009, amt=3 -> res_data=16'h0048, res_id=1; req_data changes during SETTLE do not alter the result.
REQ-033 Both requesters continuously valid (16'h8001/amt=1, 16'h00F0/amt=15) -> grants alternate 0,1,0,1 starting with 0; results are 16'h0003 and 16'h0078.
REQ-034 res_ready held low for 10 cycles in HOLD -> res_data/res_id stable, req_ready=0, busy=1; release -> IDLE on the next cycle.
REQ-035 rst pulsed on the second SETTLE cycle -> no res_valid; the next request completes normally and requester 0 wins a tie.
REQ-036 All 16 amounts applied to 16'hA5C3 -> res_data matches the rotate-left reference model each time.
